// File: rtl/l2_arbiter.sv
// Shares the single L2 cache bus between instruction fetch (A) and load/store (B), one transaction at a time.
// Grant is 1 cycle from IDLE; build with L2ARB_ROUND_ROBIN_EN for round-robin, otherwise B has fixed priority.
module l2_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 32,
    parameter int DONE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_we,
    input  logic              a_start,
    output logic [DATA_W-1:0] a_q,
    output logic              a_done,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_we,
    input  logic              b_start,
    output logic [DATA_W-1:0] b_q,
    output logic              b_done,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_data,
    output logic              l2_we,
    output logic              l2_start,
    input  logic [DATA_W-1:0] l2_q,
    input  logic              l2_done
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    localparam int CNT_W = $clog2(DONE_CYCLES + 1);

    state_t            state_q, state_d;
    logic              a_start_prev_q, a_start_prev_d, b_start_prev_q, b_start_prev_d;
    logic              a_pend_q, a_pend_d, b_pend_q, b_pend_d;
    logic              owner_q, owner_d;  // 1 = port B owns / last owned the bus
    logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
    logic [DATA_W-1:0] l2_data_q, l2_data_d;
    logic              l2_we_q, l2_we_d, l2_start_q, l2_start_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [CNT_W-1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic              a_done_q, a_done_d, b_done_q, b_done_d;
    logic              a_req, b_req, pick_b;

    always_comb begin
        a_start_prev_d = a_start;
        b_start_prev_d = b_start;
        // A request stays live only while its start is held; a drop before grant is a flush.
        a_req = a_start & (a_pend_q | ~a_start_prev_q);
        b_req = b_start & (b_pend_q | ~b_start_prev_q);
`ifdef L2ARB_ROUND_ROBIN_EN
        pick_b = b_req & (~a_req | ~owner_q);
`else
        pick_b = b_req;
`endif
        state_d    = state_q;
        a_pend_d   = a_req;
        b_pend_d   = b_req;
        owner_d    = owner_q;
        l2_addr_d  = l2_addr_q;
        l2_data_d  = l2_data_q;
        l2_we_d    = l2_we_q;
        l2_start_d = l2_start_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        a_cnt_d    = (a_cnt_q != '0) ? a_cnt_q - CNT_W'(1) : a_cnt_q;
        b_cnt_d    = (b_cnt_q != '0) ? b_cnt_q - CNT_W'(1) : b_cnt_q;

        case (state_q)
            IDLE: begin
                if (a_req | b_req) begin
                    owner_d    = pick_b;
                    l2_addr_d  = pick_b ? b_addr : a_addr;
                    l2_data_d  = pick_b ? b_data : a_data;
                    l2_we_d    = pick_b ? b_we : a_we;
                    l2_start_d = 1'b1;
                    if (pick_b) b_pend_d = 1'b0;
                    else        a_pend_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (l2_done) begin
                    l2_start_d = 1'b0;
                    state_d    = RELEASE;
                    if (owner_q && b_start) begin
                        b_rdata_d = l2_q;
                        b_cnt_d   = CNT_W'(DONE_CYCLES);
                    end else if (!owner_q && a_start) begin
                        a_rdata_d = l2_q;
                        a_cnt_d   = CNT_W'(DONE_CYCLES);
                    end
                end
            end
            RELEASE: begin
                if (!l2_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        a_done_d = (a_cnt_d != '0);
        b_done_d = (b_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            a_start_prev_q <= 1'b0;
            b_start_prev_q <= 1'b0;
            a_pend_q       <= 1'b0;
            b_pend_q       <= 1'b0;
            owner_q        <= 1'b0;
            l2_addr_q      <= '0;
            l2_data_q      <= '0;
            l2_we_q        <= 1'b0;
            l2_start_q     <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
            a_cnt_q        <= '0;
            b_cnt_q        <= '0;
            a_done_q       <= 1'b0;
            b_done_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_start_prev_q <= a_start_prev_d;
            b_start_prev_q <= b_start_prev_d;
            a_pend_q       <= a_pend_d;
            b_pend_q       <= b_pend_d;
            owner_q        <= owner_d;
            l2_addr_q      <= l2_addr_d;
            l2_data_q      <= l2_data_d;
            l2_we_q        <= l2_we_d;
            l2_start_q     <= l2_start_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
            a_cnt_q        <= a_cnt_d;
            b_cnt_q        <= b_cnt_d;
            a_done_q       <= a_done_d;
            b_done_q       <= b_done_d;
        end
    end

    assign a_q      = a_rdata_q;
    assign b_q      = b_rdata_q;
    assign a_done   = a_done_q;
    assign b_done   = b_done_q;
    assign l2_addr  = l2_addr_q;
    assign l2_data  = l2_data_q;
    assign l2_we    = l2_we_q;
    assign l2_start = l2_start_q;
endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter with a behavioural L2 cache (5-cycle latency, done held 2 cycles).
module tb_l2_arbiter;
    localparam int SEL_A_DONE = 0, SEL_B_DONE = 1, SEL_L2_DONE = 2, SEL_L2_START = 3;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] a_addr = '0, b_addr = '0, l2_addr;
    logic [31:0] a_data = '0, b_data = '0, l2_data, a_q, b_q;
    logic        a_we = 1'b0, b_we = 1'b0, a_start = 1'b0, b_start = 1'b0;
    logic        a_done, b_done, l2_we, l2_start;
    logic [31:0] l2_q = '0;
    logic        l2_done = 1'b0;

    int compared = 0, mismatched = 0;
    int cyc = 0, t_mark = 0, viol = 0;
    int a_done_hi = 0, b_done_hi = 0;
    logic [23:0] log_addr[$];
    logic        log_we[$];

    l2_arbiter dut (
        .clk(clk), .reset(reset),
        .a_addr(a_addr), .a_data(a_data), .a_we(a_we), .a_start(a_start), .a_q(a_q), .a_done(a_done),
        .b_addr(b_addr), .b_data(b_data), .b_we(b_we), .b_start(b_start), .b_q(b_q), .b_done(b_done),
        .l2_addr(l2_addr), .l2_data(l2_data), .l2_we(l2_we), .l2_start(l2_start),
        .l2_q(l2_q), .l2_done(l2_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_done === 1'b1) a_done_hi <= a_done_hi + 1;
        if (b_done === 1'b1) b_done_hi <= b_done_hi + 1;
    end

    // L2 cache model: fixed read contents, writes echo their data back on l2_q.
    int          m_state = 0, m_cnt = 0;
    logic        m_prev = 1'b0;
    logic [23:0] cap_addr = '0;
    logic [31:0] m_rdata = '0;

    function automatic logic [31:0] rom(input logic [23:0] addr);
        case (addr)
            24'h000010: return 32'hDEADBEEF;
            24'h000100: return 32'hCAFEF00D;
            24'h000300: return 32'h0BADF00D;
            default:    return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_state <= 0; m_cnt <= 0; m_prev <= 1'b0; l2_done <= 1'b0; l2_q <= '0;
        end else begin
            m_prev <= l2_start;
            case (m_state)
                0: if (l2_start && !m_prev) begin
                    cap_addr <= l2_addr;
                    log_addr.push_back(l2_addr);
                    log_we.push_back(l2_we);
                    m_rdata  <= l2_we ? l2_data : rom(l2_addr);
                    m_cnt    <= LAT - 1;
                    m_state  <= 1;
                end
                1: begin
                    if (l2_start !== 1'b1 || l2_addr !== cap_addr) viol <= viol + 1;
                    if (m_cnt == 0) begin
                        l2_done <= 1'b1; l2_q <= m_rdata; m_cnt <= 1; m_state <= 2;
                    end else m_cnt <= m_cnt - 1;
                end
                default: if (m_cnt == 0) begin
                    l2_done <= 1'b0; m_state <= 0;
                end else m_cnt <= m_cnt - 1;
            endcase
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            SEL_A_DONE:  return a_done;
            SEL_B_DONE:  return b_done;
            SEL_L2_DONE: return l2_done;
            default:     return l2_start;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_val(input int sel, input logic val, input string tag);
        int n;
        n = 0;
        while (sig(sel) !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        compared++;
        assert (sig(sel) === val) else begin
            mismatched++;
            $error("FAIL %s: observed timeout after %0d cycles expected level %0b", tag, n, val);
        end
    endtask

    initial begin
        logic [23:0] first_addr, second_addr;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_l2_start", 32'(l2_start), 32'h0);
        check("rst_l2_addr", 32'(l2_addr), 32'h0);
        check("rst_a_done", 32'(a_done), 32'h0);
        check("rst_b_done", 32'(b_done), 32'h0);
        check("rst_a_q", a_q, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // T1: A reads 0x10 alone
        a_addr = 24'h10; a_we = 1'b0; a_start = 1'b1;
        @(negedge clk);
        check("t1_grant_latency", 32'(l2_start), 32'h1);
        check("t1_l2_addr", 32'(l2_addr), 32'h10);
        check("t1_l2_we", 32'(l2_we), 32'h0);
        wait_val(SEL_L2_DONE, 1'b1, "t1_l2_done");
        t_mark = cyc;
        wait_val(SEL_A_DONE, 1'b1, "t1_a_done");
        check("t1_done_latency", 32'(cyc - t_mark), 32'h1);
        check("t1_a_q", a_q, 32'hDEADBEEF);
        a_start = 1'b0;
        @(negedge clk);
        check("t1_a_done_2nd_cycle", 32'(a_done), 32'h1);
        @(negedge clk);
        check("t1_a_done_drops", 32'(a_done), 32'h0);
        check("t1_b_done_quiet", 32'(b_done_hi), 32'h0);
        repeat (6) @(negedge clk);

        // T2: A and B rise together; B wins
        a_addr = 24'h100; a_we = 1'b0; a_start = 1'b1;
        b_addr = 24'h200; b_we = 1'b1; b_data = 32'h12345678; b_start = 1'b1;
        @(negedge clk);
        check("t2_first_addr", 32'(l2_addr), 32'h200);
        check("t2_first_we", 32'(l2_we), 32'h1);
        check("t2_first_data", l2_data, 32'h12345678);
        wait_val(SEL_B_DONE, 1'b1, "t2_b_done");
        check("t2_b_q", b_q, 32'h12345678);
        b_start = 1'b0;
        wait_val(SEL_L2_START, 1'b1, "t2_second_grant");
        check("t2_second_addr", 32'(l2_addr), 32'h100);
        check("t2_second_we", 32'(l2_we), 32'h0);
        wait_val(SEL_A_DONE, 1'b1, "t2_a_done");
        check("t2_a_q", a_q, 32'hCAFEF00D);
        a_start = 1'b0;
        repeat (6) @(negedge clk);
        check("t2_log_we", 32'(log_we[1]), 32'h1);
        check("t2_a_done_count", 32'(a_done_hi), 32'd4);
        check("t2_b_done_count", 32'(b_done_hi), 32'd2);

        // T3: B arrives while A is busy
        a_addr = 24'h10; a_start = 1'b1;
        @(negedge clk);
        check("t3_a_grant", 32'(l2_addr), 32'h10);
        b_addr = 24'h300; b_we = 1'b0; b_start = 1'b1;
        wait_val(SEL_A_DONE, 1'b1, "t3_a_done");
        check("t3_a_q", a_q, 32'hDEADBEEF);
        a_start = 1'b0;
        wait_val(SEL_L2_DONE, 1'b0, "t3_l2_done_fall");
        t_mark = cyc;
        check("t3_start_low_at_fall", 32'(l2_start), 32'h0);
        wait_val(SEL_L2_START, 1'b1, "t3_b_grant");
        check("t3_release_gap", 32'(cyc - t_mark), 32'd2);
        check("t3_b_addr", 32'(l2_addr), 32'h300);
        wait_val(SEL_B_DONE, 1'b1, "t3_b_done");
        check("t3_b_q", b_q, 32'h0BADF00D);
        b_start = 1'b0;
        repeat (6) @(negedge clk);

        // T4: A flushes during BUSY
        a_addr = 24'h100; a_start = 1'b1;
        @(negedge clk);
        check("t4_grant", 32'(l2_start), 32'h1);
        a_start = 1'b0;
        wait_val(SEL_L2_DONE, 1'b1, "t4_l2_done");
        wait_val(SEL_L2_DONE, 1'b0, "t4_l2_done_fall");
        repeat (4) @(negedge clk);
        check("t4_a_q_unchanged", a_q, 32'hDEADBEEF);
        check("t4_no_a_done", 32'(a_done_hi), 32'd6);

        // T5: A drops before grant while B busy
        b_addr = 24'h300; b_start = 1'b1;
        @(negedge clk);
        a_addr = 24'h100; a_start = 1'b1;
        repeat (2) @(negedge clk);
        a_start = 1'b0;
        wait_val(SEL_B_DONE, 1'b1, "t5_b_done");
        b_start = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_no_a_issue", 32'(log_addr.size()), 32'd7);
        check("t5_bus_idle", 32'(l2_start), 32'h0);
        check("t5_no_a_done", 32'(a_done_hi), 32'd6);

        // T6: contention after B owned the bus last
`ifdef L2ARB_ROUND_ROBIN_EN
        first_addr = 24'h10;  second_addr = 24'h300;
`else
        first_addr = 24'h300; second_addr = 24'h10;
`endif
        a_addr = 24'h10; a_start = 1'b1;
        b_addr = 24'h300; b_start = 1'b1;
        @(negedge clk);
        check("t6_first_addr", 32'(l2_addr), 32'(first_addr));
        wait_val(SEL_L2_DONE, 1'b1, "t6_first_done");
        wait_val(SEL_L2_START, 1'b0, "t6_first_release");
        wait_val(SEL_L2_START, 1'b1, "t6_second_grant");
        check("t6_second_addr", 32'(l2_addr), 32'(second_addr));
        wait_val(SEL_L2_DONE, 1'b1, "t6_second_done");
        wait_val(SEL_L2_DONE, 1'b0, "t6_second_release");
        a_start = 1'b0; b_start = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_a_done_count", 32'(a_done_hi), 32'd8);
        check("t6_b_done_count", 32'(b_done_hi), 32'd8);
        check("t6_log_size", 32'(log_addr.size()), 32'd9);

        // T7: reset in BUSY, held start re-issued afterwards
        a_addr = 24'h10; a_start = 1'b1;
        @(negedge clk);
        check("t7_grant", 32'(l2_start), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("t7_rst_l2_start", 32'(l2_start), 32'h0);
        check("t7_rst_l2_addr", 32'(l2_addr), 32'h0);
        check("t7_rst_a_q", a_q, 32'h0);
        check("t7_rst_b_q", b_q, 32'h0);
        check("t7_rst_a_done", 32'(a_done), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("t7_reissue", 32'(l2_start), 32'h1);
        check("t7_reissue_addr", 32'(l2_addr), 32'h10);
        wait_val(SEL_A_DONE, 1'b1, "t7_a_done");
        check("t7_a_q", a_q, 32'hDEADBEEF);
        a_start = 1'b0;
        repeat (6) @(negedge clk);
        check("l2_bus_stable", 32'(viol), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port arbiter that shares the single L2 cache CPU bus between the instruction-fetch port (port A) and the data/load-store port (port B). It sits between the CPU pipeline and the L2 cache and presents the same start/done handshake to each requester that the L2 cache presents to a single master. It sequences exactly one L2 transaction at a time and guarantees the L2 sees a clean rising edge of `start` per transaction.

## Interface
- `ADDR_W`, 24, address width (matches L2 bus)
- `DATA_W`, 32, data word width
- `DONE_CYCLES`, 2, cycles `done` is held to the requester (CPU runs at half clock)

Ports:
- `clk`  in  1  system clock (100 MHz, L2 clock domain)
- `reset`  in  1  synchronous, active-high
- `a_addr` / `b_addr`  in  ADDR_W  requester address
- `a_data` / `b_data`  in  DATA_W  requester write data
- `a_we` / `b_we`  in  1  write enable
- `a_start` / `b_start`  in  1  request, level held until done
- `a_q` / `b_q`  out  DATA_W  read result, registered
- `a_done` / `b_done`  out  1  completion, registered
- `l2_addr`, `l2_data`, `l2_we`, `l2_start`  out  ADDR_W/DATA_W/1/1  to L2 cache
- `l2_q`  in  DATA_W;  `l2_done`  in  1  from L2 cache

## Operation
- Reset: all outputs 0, pending flags 0, state IDLE; start history registers cleared so a `start` already high after reset counts as a new request.
- Request capture: per port, pending set on rising edge of `x_start` (start & !start_prev); pending cleared when `x_start` drops before grant (pipeline flush) or on grant.
- States: IDLE, BUSY, RELEASE.
- IDLE: if any pending (or rising edge this cycle), select winner; register winner's addr/data/we onto `l2_*`, `l2_start`<=1, record `owner`, go BUSY.
- BUSY: hold `l2_*` stable. On `l2_done`=1: `l2_start`<=0; if owner's `x_start` still high, `x_q`<=`l2_q` and `x_done` asserted for DONE_CYCLES cycles; else result discarded, no done. Go RELEASE.
- RELEASE: wait until `l2_done`=0 (L2 holds done ≥2 cycles), then IDLE. Guarantees `l2_start` low ≥1 cycle between transactions.
- `x_q` holds its value until that port's next completion.
- Simultaneous new requests on A and B in the same cycle: resolved by the priority policy (Configuration); the loser stays pending.
- Requests arriving during BUSY/RELEASE are latched as pending, never lost.
- Reset mid-transaction: abandon immediately, `l2_start`=0, no done; the L2 shares `reset`.

## Timing
- Cycle 0: rising `x_start` sampled. Edge 1: `l2_start`=1 (1-cycle grant latency from IDLE).
- `x_done` rises the edge after `l2_done` is first seen high; `x_q` valid same cycle as `x_done`.
- Back-to-back: minimum 1 RELEASE cycle after `l2_done` falls before the next `l2_start` rises.
- `l2_*` outputs are registered; no combinational path from requester inputs to L2 outputs.

## Configuration
- `L2ARB_ROUND_ROBIN_EN` defined: round-robin; on contention, grant the port that did not own the last transaction (initial preference after reset: B).
- Undefined: fixed priority, port B (data) always wins contention; port A can wait for B's stream.

## Test plan
- A read 0x000010 alone, L2 model returns 0xDEADBEEF after 5 cycles -> `l2_start` rises 1 cycle after `a_start`, `a_q`=0xDEADBEEF, `a_done` high 2 cycles, `b_done` stays 0.
- A and B rise same cycle (A read 0x100, B write 0x200=0x12345678) -> fixed: B first, then A; round-robin after reset: B first, then A; next contention goes to A.
- B raises start while A in BUSY -> B pending, `l2_start` low ≥1 cycle after `l2_done` falls, then B issued with `l2_addr`=b_addr.
- A drops `a_start` during BUSY (flush) -> L2 transaction completes, `a_done` never asserts, `a_q` unchanged.
- A drops start before grant while B busy -> A pending cleared, no A transaction issued.
- Reset asserted in BUSY -> next cycle all outputs 0, state IDLE; a held-high `a_start` after reset is issued as new request.
